// File: rtl/auv_csr_file_if.sv
// rtl/auv_csr_file_if.sv - CSR space bus between the CSR instruction unit and the CSR bank
interface auv_csr_file_if;
  logic [11:0] cbus_adr;
  logic [31:0] cbus_dat_wr;
  logic [31:0] cbus_dat_rd;
  logic        cbus_rd;
  logic        cbus_wr;
  logic        cbus_ack;

  modport master (
    output cbus_adr, cbus_dat_wr, cbus_rd, cbus_wr,
    input  cbus_dat_rd, cbus_ack
  );

  modport slave (
    input  cbus_adr, cbus_dat_wr, cbus_rd, cbus_wr,
    output cbus_dat_rd, cbus_ack
  );
endinterface

// File: rtl/auv_csr_file.sv
// rtl/auv_csr_file.sv - machine-mode CSR bank with trap/mret handling and 64-bit counters
module auv_csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  auv_csr_file_if.slave     cbus,
  input  logic              inst_retire,
  input  logic              trap_en,
  input  logic [31:0]       trap_cause,
  input  logic [31:0]       trap_pc,
  input  logic [31:0]       trap_val,
  input  logic              mret,
  input  logic              irq_ext,
  input  logic              irq_tmr,
  input  logic              irq_sw,
  output logic [31:0]       mtvec_o,
  output logic [31:0]       mepc_o,
  output logic              irq_take
);

  logic        mie_bit, mpie_bit;
  logic [31:0] mie_reg, mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] cycle, instret;
  logic [31:0] mstatus_val, mip_val, rdata;
  logic        known, ro, wr_ok, rd_ok, evt;
  logic [11:0] adr;
  logic [31:0] wdat;

  assign adr         = cbus.cbus_adr;
  assign wdat        = cbus.cbus_dat_wr;
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_bit, 3'b0, mie_bit, 3'b0};
  assign mip_val     = {20'b0, irq_ext, 3'b0, irq_tmr, 3'b0, irq_sw, 3'b0};
  assign evt         = trap_en | mret;
  assign mtvec_o     = mtvec;
  assign mepc_o      = mepc;

  always_comb begin
    rdata = '0;
    known = 1'b1;
    case (adr)
      12'h300:          rdata = mstatus_val;
      12'h301:          rdata = MISA_VAL;
      12'h304:          rdata = mie_reg;
      12'h305:          rdata = mtvec;
      12'h340:          rdata = mscratch;
      12'h341:          rdata = mepc;
      12'h342:          rdata = mcause;
      12'h343:          rdata = mtval;
      12'h344:          rdata = mip_val;
      12'hB00, 12'hC00: rdata = cycle[31:0];
      12'hB80, 12'hC80: rdata = cycle[63:32];
      12'hB02, 12'hC02: rdata = instret[31:0];
      12'hB82, 12'hC82: rdata = instret[63:32];
      12'hF14:          rdata = HART_ID;
      default:          known = 1'b0;
    endcase
  end

  // Read-only: whole 0xC00-0xFFF quadrant plus misa and mip
  assign ro    = (adr[11:10] == 2'b11) || (adr == 12'h301) || (adr == 12'h344);
  assign wr_ok = cbus.cbus_wr & known & ~ro;
  assign rd_ok = cbus.cbus_rd & ~cbus.cbus_wr & known;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cbus.cbus_ack    <= 1'b0;
      cbus.cbus_dat_rd <= '0;
      irq_take         <= 1'b0;
    end else begin
      cbus.cbus_ack <= wr_ok | rd_ok;
      if (rd_ok) cbus.cbus_dat_rd <= rdata;
      irq_take <= mie_bit & |(mip_val & mie_reg);
    end
  end

  // Trap/mret own mstatus, mepc, mcause and mtval; a coincident bus write to them is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_bit  <= 1'b0;
      mpie_bit <= 1'b0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap_en) begin
      mpie_bit <= mie_bit;
      mie_bit  <= 1'b0;
      mepc     <= trap_pc & ~32'h3;
      mcause   <= trap_cause;
      mtval    <= trap_val;
    end else if (mret) begin
      mie_bit  <= mpie_bit;
      mpie_bit <= 1'b1;
    end else if (wr_ok && !evt) begin
      case (adr)
        12'h300: begin
          mie_bit  <= wdat[3];
          mpie_bit <= wdat[7];
        end
        12'h341: mepc   <= wdat & ~32'h3;
        12'h342: mcause <= wdat;
        12'h343: mtval  <= wdat;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_reg  <= '0;
      mtvec    <= RESET_MTVEC & ~32'h3;
      mscratch <= '0;
    end else if (wr_ok) begin
      case (adr)
        12'h304: mie_reg  <= wdat & 32'h0000_0888;
        12'h305: mtvec    <= wdat & ~32'h3;
        12'h340: mscratch <= wdat;
        default: ;
      endcase
    end
  end

  // A written half takes the bus value; the other half keeps counting without a carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle   <= '0;
      instret <= '0;
    end else begin
      if (wr_ok && adr == 12'hB00)      cycle <= {cycle[63:32], wdat};
      else if (wr_ok && adr == 12'hB80) cycle <= {wdat, cycle[31:0] + 32'd1};
      else                              cycle <= cycle + 64'd1;

      if (wr_ok && adr == 12'hB02)      instret <= {instret[63:32], wdat};
      else if (wr_ok && adr == 12'hB82) instret <= {wdat, instret[31:0] + {31'b0, inst_retire}};
      else if (inst_retire)             instret <= instret + 64'd1;
    end
  end

endmodule
